// File: rtl/jtag_host_sequencer.sv
// rtl/jtag_host_sequencer.sv - command-driven JTAG host: walks the TAP from Run-Test/Idle and back, capturing TDO
module jtag_host_sequencer #(
    parameter int MAX_LEN          = 32,
    parameter int RESET_TMS_CYCLES = 5,
    localparam int LW              = $clog2(MAX_LEN + 1)
) (
    input  logic               clk_tck,
    input  logic               trst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [LW-1:0]      cmd_len,
    input  logic [MAX_LEN-1:0] cmd_data,
    output logic               tms,
    output logic               tdi,
    output logic               tap_enable,
    input  logic               tdo,
    output logic               rsp_valid,
    output logic               rsp_error,
    output logic [MAX_LEN-1:0] rsp_data
);

    localparam logic [1:0] OP_RESET = 2'd0;
    localparam logic [1:0] OP_IR    = 2'd1;
    localparam logic [1:0] OP_IDLE  = 2'd3;

    localparam logic [LW-1:0] RST_ONES = LW'(RESET_TMS_CYCLES);
    localparam logic [LW-1:0] RST_LAST = LW'(RESET_TMS_CYCLES + 1);
    localparam logic [LW-1:0] LEN_MAX  = LW'(MAX_LEN);

    typedef enum logic [2:0] {
        H_IDLE,
        H_RESET,
        H_PRE,
        H_SHIFT,
        H_POST,
        H_DONE
    } state_t;

    state_t             state, state_n;
    logic [LW-1:0]      cnt, cnt_n;
    logic [1:0]         op_q, op_n;
    logic [LW-1:0]      len_q, len_n;
    logic [MAX_LEN-1:0] data_q, data_n;
    logic               auto_q, auto_n;
    logic               err_q, err_n;
    logic               accept;
    logic [LW-1:0]      pre_last;
    logic [MAX_LEN-1:0] data_sh;
    logic               tms_n, tdi_n;

    assign accept   = cmd_valid && cmd_ready;
    assign pre_last = (op_q == OP_IR) ? LW'(3) : LW'(2);

    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            state  <= H_RESET;
            cnt    <= '0;
            op_q   <= OP_RESET;
            len_q  <= '0;
            data_q <= '0;
            auto_q <= 1'b1;
            err_q  <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            op_q   <= op_n;
            len_q  <= len_n;
            data_q <= data_n;
            auto_q <= auto_n;
            err_q  <= err_n;
        end
    end

    // Next-state: cnt is the cycle index within the current phase.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        len_n   = len_q;
        data_n  = data_q;
        auto_n  = auto_q;
        err_n   = err_q;
        case (state)
            H_IDLE: begin
                if (accept) begin
                    op_n   = cmd_op;
                    len_n  = cmd_len;
                    data_n = cmd_data;
                    err_n  = 1'b0;
                    auto_n = 1'b0;
                    cnt_n  = '0;
                    if (cmd_op == OP_RESET) begin
                        state_n = H_RESET;
                        cnt_n   = LW'(1);
                    end else if (cmd_len == '0 || cmd_len > LEN_MAX) begin
                        state_n = H_DONE;
                        err_n   = 1'b1;
                    end else if (cmd_op == OP_IDLE) begin
                        state_n = H_SHIFT;
                    end else begin
                        state_n = H_PRE;
                    end
                end
            end
            H_RESET: begin
                if (cnt == RST_LAST) begin
                    // The power-on sequence finishes silently; a commanded one reports completion.
                    state_n = auto_q ? H_IDLE : H_DONE;
                    cnt_n   = '0;
                    auto_n  = 1'b0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            H_PRE: begin
                if (cnt == pre_last) begin
                    state_n = H_SHIFT;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            H_SHIFT: begin
                if (cnt == len_q - 1'b1) begin
                    state_n = (op_q == OP_IDLE) ? H_DONE : H_POST;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            H_POST: begin
                if (cnt == LW'(1)) begin
                    state_n = H_DONE;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            H_DONE: begin
                state_n = H_IDLE;
                cnt_n   = '0;
            end
            default: begin
                state_n = H_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Pin values are decoded from the next state so they land in flops on the same edge.
    always_comb begin
        tms_n   = 1'b0;
        tdi_n   = 1'b0;
        data_sh = data_n >> cnt_n;
        case (state_n)
            H_RESET: tms_n = (cnt_n <= RST_ONES);
            H_PRE:   tms_n = (cnt_n == '0) || (op_n == OP_IR && cnt_n == LW'(1));
            H_SHIFT: begin
                if (op_n != OP_IDLE) begin
                    tdi_n = data_sh[0];
                    tms_n = (cnt_n == len_n - 1'b1);
                end
            end
            H_POST:  tms_n = (cnt_n == '0);
            default: tms_n = 1'b0;
        endcase
    end

    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            tms        <= 1'b1;
            tdi        <= 1'b0;
            tap_enable <= 1'b0;
            cmd_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_error  <= 1'b0;
        end else begin
            tms        <= tms_n;
            tdi        <= tdi_n;
            tap_enable <= 1'b1;
            cmd_ready  <= (state_n == H_IDLE);
            rsp_valid  <= (state_n == H_DONE);
            rsp_error  <= (state_n == H_DONE) && err_n;
        end
    end

    // TDO for bit i is taken on the edge that ends the cycle driving bit i.
    always_ff @(posedge clk_tck or negedge trst_n) begin
        if (!trst_n) begin
            rsp_data <= '0;
        end else if (accept) begin
            rsp_data <= '0;
        end else if (state == H_SHIFT && op_q != OP_IDLE) begin
            rsp_data <= rsp_data | ({{(MAX_LEN-1){1'b0}}, tdo} << cnt);
        end
    end

endmodule
